io_out_buffer: RTL
==================

IO_OUT_BUFFER -- requirements
Module: io_out_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, >= 4.
REQ-002 Parameter GAP, default 2, idle cycles forced after each accepted output byte (0 allowed).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  mem stage writes one byte to the IO output port this cycle.
REQ-006 wr_data  input  8  byte to enqueue.
REQ-007 out_valid  output  1  byte available to the host/UART side (registered).
REQ-008 out_data  output  8  head-of-queue byte, stable while out_valid=1 and out_ready=0.
REQ-009 out_ready  input  1  host accepts out_data when out_valid=1.
REQ-010 io_buffer_full  output  1  stall request to the pipeline stall controller (registered).
REQ-011 overflow  output  1  sticky flag: a write was dropped.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-013 FIFO: circular storage, rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH.
REQ-014 Push when wr_en=1 and count<DEPTH; push at count==DEPTH is dropped, sets overflow, and leaves storage/count unchanged.
REQ-015 Pop occurs exactly when out_valid=1 and out_ready=1 in the same cycle.
REQ-016 Simultaneous push and pop: count unchanged, both pointers advance; legal at count==DEPTH, because the pop is evaluated first and the push is then not dropped.
REQ-017 io_buffer_full=1 when next-cycle count >= DEPTH-1; one slot of headroom absorbs the write issued in the same cycle as the stall.
REQ-018 FSM states IDLE, SEND, HOLD; encoding is free.
REQ-019 IDLE: out_valid=0; go to SEND when count>0 (a push into an empty FIFO gives out_valid=1 one cycle after the wr_en cycle).
REQ-020 SEND: out_valid=1, out_data=mem[rd_ptr]; on handshake go to HOLD with gap counter = GAP if GAP>0; else go to SEND if post-pop count>0, otherwise IDLE.
REQ-021 HOLD: out_valid=0; decrement the gap counter each cycle; at 1, go to SEND if count>0, else IDLE.
REQ-022 Pushes are accepted in every state; the FSM never blocks writes.
REQ-023 Without a handshake, SEND holds out_valid and out_data constant indefinitely.
REQ-024 overflow clears only on reset.

Reset
REQ-025 Assertion of rst_n=0 SHALL immediately force: state=IDLE, pointers=0, count=0, gap counter=0, out_valid=0, out_data=0, io_buffer_full=0, overflow=0.
REQ-026 Reset mid-transfer SHALL discard all queued bytes; no handshake completes in the cycle in which rst_n is low.
REQ-027 Storage array contents need not be reset.

Structure
REQ-028 The FSM state typedef and the GAP/DEPTH defaults SHALL live in the shared CPU config package, alongside the True/False constants.
REQ-029 The FIFO storage with its pointers SHALL be one sub-module, io_fifo; the FSM and gap counter stay in io_out_buffer.

Verification
REQ-030 Single byte: with GAP=2, write 0x41 at cycle 0 with out_ready=1 -> out_valid=1 at cycle 1 with out_data=0x41; pop at cycle 1; out_valid=0 at cycles 2-3; count=0.
REQ-031 Burst with backpressure: write 0x10..0x17 on consecutive cycles with out_ready=0 -> io_buffer_full rises the cycle count reaches 7; count=8; overflow=0; out_data stays 0x10.
REQ-032 Overflow: with count=8 and out_ready=0, write 0x99 -> dropped; overflow=1; count stays 8; the drained sequence is 0x10..0x17.
REQ-033 Simultaneous: with count=8 in SEND, apply wr_en=1 (0x55) and out_ready=1 -> count stays 8; overflow stays 0; 0x55 is drained last.
REQ-034 Gap pacing: with GAP=0 and 3 queued bytes, hold out_ready=1 -> out_valid stays high for 3 consecutive cycles, then IDLE.
REQ-035 Reset mid-operation: pull rst_n low while in SEND with count=5 -> out_valid=0, count=0 and io_buffer_full=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/io_out_buffer_pkg.sv
// Shared CPU configuration: boolean constants, IO output buffer defaults and FSM state type.
package io_out_buffer_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned GAP_DEFAULT   = 2;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } out_state_e;

endpackage

// File: rtl/io_fifo.sv
// Circular byte FIFO with occupancy counter; exposes next-cycle count and head for registered consumers.
module io_fifo
    import io_out_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_req,
    input  logic                       pop,
    input  logic [BYTE_W-1:0]          wr_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_next_c,
    output logic [BYTE_W-1:0]          head_next_c,
    output logic                       drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr_next;
    logic              do_pop;
    logic              do_push;

    // Pop is resolved first, so a push into a full FIFO is kept when a pop frees a slot.
    always_comb begin
        do_pop      = pop && (count != CW'(0));
        do_push     = push_req && ((count < CW'(DEPTH)) || do_pop);
        drop_c      = push_req && !do_push;
        rd_ptr_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next_c = count;
        if (do_push && !do_pop) begin
            count_next_c = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next_c = count - CW'(1);
        end
        head_next_c = (do_push && (rd_ptr_next == wr_ptr)) ? wr_data : mem[rd_ptr_next];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_next;
            count  <= count_next_c;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/io_out_buffer.sv
// IO output buffer: queues bytes from the mem stage and paces them to the host with idle gaps.
module io_out_buffer
    import io_out_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned GAP   = GAP_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [BYTE_W-1:0]          wr_data,
    output logic                       out_valid,
    output logic [BYTE_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic                       io_buffer_full,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    out_state_e        state;
    out_state_e        state_d;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     gap_d;
    logic              pop;
    logic              valid_d;
    logic [BYTE_W-1:0] data_d;
    logic [CW-1:0]     count_next;
    logic [BYTE_W-1:0] head_next;
    logic              drop;

    assign pop = out_valid && out_ready;

    io_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_req     (wr_en),
        .pop          (pop),
        .wr_data      (wr_data),
        .count        (count),
        .count_next_c (count_next),
        .head_next_c  (head_next),
        .drop_c       (drop)
    );

    // Next state looks at next-cycle occupancy so a write into an empty FIFO is visible one cycle later.
    always_comb begin
        state_d = state;
        gap_d   = gap_cnt;
        case (state)
            ST_IDLE: begin
                if (count_next != CW'(0)) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (pop) begin
                    if (GAP > 0) begin
                        state_d = ST_HOLD;
                        gap_d   = GW'(GAP);
                    end else begin
                        state_d = (count_next != CW'(0)) ? ST_SEND : ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (gap_cnt <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = (count_next != CW'(0)) ? ST_SEND : ST_IDLE;
                end else begin
                    gap_d = gap_cnt - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_SEND);
        data_d  = (valid_d && (!out_valid || pop)) ? head_next : out_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            gap_cnt        <= '0;
            out_valid      <= FALSE;
            out_data       <= '0;
            io_buffer_full <= FALSE;
            overflow       <= FALSE;
        end else begin
            state          <= state_d;
            gap_cnt        <= gap_d;
            out_valid      <= valid_d;
            out_data       <= data_d;
            io_buffer_full <= (count_next >= CW'(DEPTH - 1));
            if (drop) overflow <= TRUE;
        end
    end

endmodule
